// File: rtl/pc_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and default
// geometry constants.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_STEP     = 1;
  localparam int DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO where a push into a full stack
// overwrites the oldest entry and the count saturates at DEPTH.
module pc_ras #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW:0]      r_count;
  logic [PW-1:0]    w_top_ptr;

  assign w_top_ptr = r_wr_ptr - PW'(1);
  assign o_top     = r_mem[w_top_ptr];
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // The pointer wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_push) begin
      r_wr_ptr <= r_wr_ptr + PW'(1);
      if (!o_full) r_count <= r_count + (PW+1)'(1);
    end else if (i_pop && !o_empty) begin
      r_wr_ptr <= w_top_ptr;
      r_count  <= r_count - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with IDLE/RUN/HALTED control and redirect/call/return.
// The return-address stack is built only when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int STEP      = DEFAULT_STEP,
  parameter int RESET_PC  = DEFAULT_RESET_PC,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  input  logic             pc_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             halt,
  input  logic             call,
  input  logic             ret,
  output logic             ras_empty
);

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PC);

  pc_state_e        r_state;
  pc_state_e        w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_pc_inc;
  logic             w_handshake;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;

  assign pc          = r_pc;
  assign pc_valid    = (r_state == RUN);
  assign w_handshake = pc_valid && pc_ready;
  assign w_pc_inc    = r_pc + STEP_W;
  assign ras_empty   = w_ras_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_W;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Priority: redirect, then halt, then ret/sequential advance on handshake.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: w_state_next = RUN;
      RUN, HALTED: begin
        if (redirect) begin
          w_pc_next    = redirect_target;
          w_push       = call;
          w_state_next = halt ? HALTED : RUN;
        end else if (r_state == RUN) begin
          if (halt) begin
            w_state_next = HALTED;
          end else if (w_handshake) begin
            if (ret && !w_ras_empty) begin
              w_pc_next = w_ras_top;
              w_pop     = 1'b1;
            end else begin
              w_pc_next = w_pc_inc;
            end
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef PC_SEQUENCER_RAS_EN
  logic w_unused_full;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_unused_full)
  );
`else
  // Without a stack, call is ignored and ret always degrades to an advance.
  logic w_unused_ras;
  assign w_unused_ras = ^{w_push, w_pop};
  assign w_ras_top    = '0;
  assign w_ras_empty  = 1'b1;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against a queue-based
// behavioural model; follows PC_SEQUENCER_RAS_EN like the design does.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif
  localparam int RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        halt;
  logic        call;
  logic        ret;
  logic        ras_empty;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode 0 = idle, 1 = running, 2 = halted; RAS as a queue (back = top).
  logic [15:0] m_pc;
  int          m_mode;
  logic [15:0] m_ras[$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH(16), .STEP(1), .RESET_PC(0), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .pc_ready        (pc_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .call            (call),
    .ret             (ret),
    .ras_empty       (ras_empty)
  );

  task automatic model_reset();
    m_pc   = 16'h0000;
    m_mode = 0;
    m_ras.delete();
  endtask

  task automatic model_step();
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (redirect) begin
      if (call && RAS_EN) begin
        m_ras.push_back(m_pc + 16'd1);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end
      m_pc   = redirect_target;
      m_mode = halt ? 2 : 1;
    end else if (m_mode == 1) begin
      if (halt) m_mode = 2;
      else if (pc_ready) begin
        if (ret && m_ras.size() > 0) m_pc = m_ras.pop_back();
        else m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_quiet();
    pc_ready = 1'b1; redirect = 1'b0; redirect_target = 16'h0;
    halt = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic test_reset();
    drive_quiet();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (pc !== 16'h0000) begin n_errors++; $display("FAIL reset_pc: got %h want 0000", pc); end
    n_checks++; if (pc_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
    n_checks++; if (ras_empty !== 1'b1) begin n_errors++; $display("FAIL reset_ras_empty: got %b want 1", ras_empty); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (pc_valid !== 1'b0 || pc !== 16'h0000) begin n_errors++; $display("FAIL release_idle: got pc=%h valid=%b want 0000/0", pc, pc_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (pc !== 16'(i) || pc_valid !== 1'b1) begin
        n_errors++; $display("FAIL startup_seq[%0d]: got pc=%h valid=%b want %h/1", i, pc, pc_valid, 16'(i));
      end
      $display("startup cycle %0d: pc=%h valid=%b", i, pc, pc_valid);
    end
  endtask

  task automatic test_wrap();
    drive_quiet();
    redirect = 1'b1; redirect_target = 16'hFFFF;
    tick();
    drive_quiet();
    n_checks++; if (pc !== 16'hFFFF) begin n_errors++; $display("FAIL wrap_load: got %h want ffff", pc); end
    tick();
    n_checks++; if (pc !== 16'h0000 || pc !== m_pc) begin n_errors++; $display("FAIL wrap: got %h want 0000", pc); end
    $display("wrap: pc=%h", pc);
  endtask

  task automatic test_call_ret();
    drive_quiet();
    redirect = 1'b1; redirect_target = 16'h0010;
    tick();
    redirect_target = 16'h0200; call = 1'b1;
    tick();
    drive_quiet();
    n_checks++; if (pc !== 16'h0200) begin n_errors++; $display("FAIL call_target: got %h want 0200", pc); end
    n_checks++; if (ras_empty !== (m_ras.size() == 0)) begin n_errors++; $display("FAIL call_ras_empty: got %b want %b", ras_empty, m_ras.size() == 0); end
    ret = 1'b1;
    tick();
    ret = 1'b0;
    n_checks++;
    if (pc !== (RAS_EN ? 16'h0011 : 16'h0201)) begin
      n_errors++; $display("FAIL ret_pc: got %h want %h", pc, RAS_EN ? 16'h0011 : 16'h0201);
    end
    n_checks++; if (ras_empty !== 1'b1) begin n_errors++; $display("FAIL ret_ras_empty: got %b want 1", ras_empty); end
    $display("call/ret: pc=%h ras_empty=%b", pc, ras_empty);
  endtask

  task automatic test_ras_overflow();
    logic [15:0] targets [5];
    for (int i = 0; i < 5; i++) targets[i] = 16'h1000 + 16'(i * 16'h0100);
    drive_quiet();
    for (int i = 0; i < 5; i++) begin
      redirect = 1'b1; call = 1'b1; redirect_target = targets[i];
      tick();
      n_checks++; if (pc !== targets[i]) begin n_errors++; $display("FAIL push_pc[%0d]: got %h want %h", i, pc, targets[i]); end
    end
    drive_quiet();
    ret = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (pc !== m_pc || ras_empty !== (m_ras.size() == 0)) begin
        n_errors++; $display("FAIL pop[%0d]: got pc=%h empty=%b want %h/%b", i, pc, ras_empty, m_pc, m_ras.size() == 0);
      end
      $display("ret %0d: pc=%h ras_empty=%b", i, pc, ras_empty);
    end
    ret = 1'b0;
  endtask

  task automatic test_halt();
    logic [15:0] held;
    drive_quiet();
    held = pc;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_checks++; if (pc_valid !== 1'b0 || pc !== held) begin n_errors++; $display("FAIL halt_enter: got pc=%h valid=%b want %h/0", pc, pc_valid, held); end
    repeat (3) tick();
    n_checks++; if (pc_valid !== 1'b0 || pc !== held) begin n_errors++; $display("FAIL halt_hold: got pc=%h valid=%b want %h/0", pc, pc_valid, held); end
    redirect = 1'b1; redirect_target = 16'h0100;
    tick();
    drive_quiet();
    n_checks++; if (pc_valid !== 1'b1 || pc !== 16'h0100) begin n_errors++; $display("FAIL halt_exit: got pc=%h valid=%b want 0100/1", pc, pc_valid); end
    $display("halt/resume: pc=%h valid=%b", pc, pc_valid);
  endtask

  task automatic test_async_reset();
    drive_quiet();
    redirect = 1'b1; redirect_target = 16'h0042;
    tick();
    drive_quiet();
    pc_ready = 1'b0;
    @(posedge clk);
    model_step();
    #2;
    n_checks++; if (pc !== 16'h0042 || pc_valid !== 1'b1) begin n_errors++; $display("FAIL pre_reset: got pc=%h valid=%b want 0042/1", pc, pc_valid); end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (pc !== 16'h0000 || pc_valid !== 1'b0 || ras_empty !== 1'b1) begin
      n_errors++; $display("FAIL async_reset: got pc=%h valid=%b empty=%b want 0000/0/1", pc, pc_valid, ras_empty);
    end
    $display("async reset: pc=%h valid=%b", pc, pc_valid);
    @(negedge clk);
    rst_n = 1'b1;
    drive_quiet();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      pc_ready        = ($urandom_range(0, 3) != 0);
      redirect        = ($urandom_range(0, 9) == 0);
      redirect_target = 16'($urandom);
      call            = $urandom_range(0, 1) == 1;
      ret             = ($urandom_range(0, 3) == 0);
      halt            = ($urandom_range(0, 19) == 0);
      tick();
      n_checks++;
      if (pc !== m_pc || pc_valid !== (m_mode == 1) || ras_empty !== (m_ras.size() == 0)) begin
        n_errors++;
        $display("FAIL random[%0d]: got pc=%h valid=%b empty=%b want %h/%b/%b",
                 i, pc, pc_valid, ras_empty, m_pc, m_mode == 1, m_ras.size() == 0);
      end
      $display("rand %0d: rdr=%b hlt=%b ret=%b rdy=%b pc=%h valid=%b", i, redirect, halt, ret, pc_ready, pc, pc_valid);
    end
    drive_quiet();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_call_ret();
    test_ras_overflow();
    test_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
